// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding, step count and parameter legality for serial_adder
package serial_adder_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic int calc_n(input int w, input int d);
    return w / d;
  endfunction
  function automatic bit legal(input int w, input int d);
    return (d > 0) && (w >= 2) && (w % d == 0);
  endfunction
endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple slice, also exposing the carry into its MSB
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);
  logic [DIGIT:0] w_c;
  always_comb begin
    w_c = '0;
    s_d = '0;
    w_c[0] = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i] = a_d[i] ^ b_d[i] ^ w_c[i];
      w_c[i+1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
    end
  end
  assign c_out = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock through a registered carry.
// SERIAL_ADDER_SUB_EN adds a sub port selecting a-b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = calc_n(WIDTH, DIGIT);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (!legal(WIDTH, DIGIT)) begin : g_bad
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_cm;
  logic [WIDTH-1:0] w_acc_nxt;
  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a_d(r_a[DIGIT-1:0]),
    .b_d(r_b[DIGIT-1:0]),
    .c_in(r_c),
    .s_d(w_s),
    .c_out(w_co),
    .c_msb_in(w_cm)
  );
  // new digit enters at the top so after N steps digit 0 sits at the LSB
  assign w_acc_nxt = (WIDTH'(w_s) << (WIDTH - DIGIT)) | (r_acc >> DIGIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_c <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_state <= RUN;
          r_cnt <= '0;
          r_a <= a;
          busy <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
          r_b <= sub ? ~b : b;
          r_c <= sub | cin;
`else
          r_b <= b;
          r_c <= cin;
`endif
        end
      end else begin
        r_a <= r_a >> DIGIT;
        r_b <= r_b >> DIGIT;
        r_c <= w_co;
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          sum <= w_acc_nxt;
          cout <= w_co;
          ovf <= w_cm ^ w_co;
        end
      end
    end
  end
endmodule
